// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sr_ctrl_pkg
// Brief    : Shared types and constants for the SR flag-bank sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sr_ctrl_pkg;

  // Sequencer states: one command moves IDLE -> DRIVE -> CHECK -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Command opcodes carried on req_op.
  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first active request at or
//            after the priority pointer; one-hot grant plus encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_vld
);

  // Scan NREQ positions starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!grant_vld && req[PW'(cand)]) begin
        grant_vld          = 1'b1;
        grant[PW'(cand)]   = 1'b1;
        grant_idx          = PW'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_flag_ctrl
// Brief    : Round-robin sequencer that writes a bank of SR flops with single
//            S or R pulses, verifies each write by reading Q back, retries a
//            bounded number of times and records a sticky error otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module sr_flag_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NFLAG     = 8,
  parameter int IDXW      = 3,
  parameter int MAX_RETRY = 2,
  parameter int REQW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAG-1:0]     flag_S,
  output logic [NFLAG-1:0]     flag_R,
  input  logic [NFLAG-1:0]     flag_Q,
  output logic                 done,
  output logic [REQW-1:0]      done_req,
  output logic                 err,
  output logic [IDXW-1:0]      err_idx,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e           state_q,   state_d;
  logic             cmd_op_q,  cmd_op_d;
  logic [IDXW-1:0]  cmd_idx_q, cmd_idx_d;
  logic [REQW-1:0]  cmd_req_q, cmd_req_d;
  logic [REQW-1:0]  ptr_q,     ptr_d;
  logic [RW-1:0]    retry_q,   retry_d;
  logic [NFLAG-1:0] flag_S_q,  flag_S_d;
  logic [NFLAG-1:0] flag_R_q,  flag_R_d;
  logic             done_q,    done_d;
  logic [REQW-1:0]  done_req_q, done_req_d;
  logic             err_q,     err_d;
  logic [IDXW-1:0]  err_idx_q, err_idx_d;

  logic [NREQ-1:0]  grant;
  logic [REQW-1:0]  grant_idx;
  logic             grant_vld;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_op;
  logic             sel_in_range;
  logic [NFLAG-1:0] sel_mask;
  logic [NFLAG-1:0] cmd_mask;
  logic             q_match;
  logic             new_err;
  logic [IDXW-1:0]  new_err_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (REQW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Decode the winning requester's command and the latched command's target.
  always_comb begin
    sel_idx      = req_idx[grant_idx*IDXW +: IDXW];
    sel_op       = req_op[grant_idx];
    sel_in_range = (32'(sel_idx) < NFLAG);
    sel_mask     = NFLAG'(1'b1) << sel_idx;
    cmd_mask     = NFLAG'(1'b1) << cmd_idx_q;
    q_match      = ((flag_Q & cmd_mask) != '0) == cmd_op_q;
  end

  // Next-state, command latch, S/R pulse decode and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_op_d    = cmd_op_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_req_d   = cmd_req_q;
    ptr_d       = ptr_q;
    retry_d     = retry_q;
    flag_S_d    = '0;
    flag_R_d    = '0;
    done_d      = 1'b0;
    done_req_d  = done_req_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    req_ready   = '0;
    new_err     = 1'b0;
    new_err_idx = '0;

    if (err_clr) begin
      err_d     = 1'b0;
      err_idx_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          // Grant is suppressed while reset is held so no handshake can complete.
          req_ready = rst_n ? grant : '0;
          cmd_op_d  = sel_op;
          cmd_idx_d = sel_idx;
          cmd_req_d = grant_idx;
          ptr_d     = (grant_idx == REQW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          if (sel_in_range) begin
            state_d  = DRIVE;
            retry_d  = '0;
            // S/R are registered: loading them now puts the pulse in DRIVE.
            flag_S_d = (sel_op == OP_SET) ? sel_mask : '0;
            flag_R_d = (sel_op == OP_RST) ? sel_mask : '0;
          end else begin
            new_err     = 1'b1;
            new_err_idx = sel_idx;
          end
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_match) begin
          done_d     = 1'b1;
          done_req_d = cmd_req_q;
          retry_d    = '0;
          state_d    = IDLE;
        end else if (32'(retry_q) < MAX_RETRY) begin
          retry_d  = retry_q + 1'b1;
          state_d  = DRIVE;
          flag_S_d = (cmd_op_q == OP_SET) ? cmd_mask : '0;
          flag_R_d = (cmd_op_q == OP_RST) ? cmd_mask : '0;
        end else begin
          new_err     = 1'b1;
          new_err_idx = cmd_idx_q;
          retry_d     = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new error overrides a same-cycle clear; the index is kept from the
    // first error since the flag was last clear.
    if (new_err) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_idx_d = new_err_idx;
      end
    end
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_op_q   <= 1'b0;
      cmd_idx_q  <= '0;
      cmd_req_q  <= '0;
      ptr_q      <= '0;
      retry_q    <= '0;
      flag_S_q   <= '0;
      flag_R_q   <= '0;
      done_q     <= 1'b0;
      done_req_q <= '0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      cmd_idx_q  <= cmd_idx_d;
      cmd_req_q  <= cmd_req_d;
      ptr_q      <= ptr_d;
      retry_q    <= retry_d;
      flag_S_q   <= flag_S_d;
      flag_R_q   <= flag_R_d;
      done_q     <= done_d;
      done_req_q <= done_req_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign flag_S   = flag_S_q;
  assign flag_R   = flag_R_q;
  assign done     = done_q;
  assign done_req = done_req_q;
  assign err      = err_q;
  assign err_idx  = err_idx_q;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_flag_ctrl
// Brief    : Self-checking bench for sr_flag_ctrl with an SR bank model and a
//            done scoreboard; a second instance uses a 6-flag bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_flag_ctrl;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NREQ-1:0]      req_valid, req_op, req_ready;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NFLAG-1:0]     flag_S, flag_R, flag_Q;
  logic                 done, err, err_clr, busy;
  logic [1:0]           done_req;
  logic [IDXW-1:0]      err_idx;

  logic [NREQ-1:0]      b_valid, b_op, b_ready;
  logic [NREQ*IDXW-1:0] b_idx;
  logic [5:0]           b_flag_S, b_flag_R;
  logic                 b_done, b_err, b_err_clr, b_busy;
  logic [1:0]           b_done_req;
  logic [IDXW-1:0]      b_err_idx;

  logic [NFLAG-1:0] bank_q;
  logic [NFLAG-1:0] stuck0;
  int checks = 0;
  int failures = 0;
  int mptr = 0;
  int inv_viol = 0;
  int b_act = 0;
  int b_done_cnt = 0;
  int sb_req[$];
  int sb_due[$];

  sr_flag_ctrl #(.NREQ(4), .NFLAG(8), .IDXW(3), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .flag_S(flag_S), .flag_R(flag_R),
    .flag_Q(flag_Q), .done(done), .done_req(done_req), .err(err),
    .err_idx(err_idx), .err_clr(err_clr), .busy(busy)
  );

  sr_flag_ctrl #(.NREQ(4), .NFLAG(6), .IDXW(3), .MAX_RETRY(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_op(b_op),
    .req_idx(b_idx), .req_ready(b_ready), .flag_S(b_flag_S), .flag_R(b_flag_R),
    .flag_Q(6'h00), .done(b_done), .done_req(b_done_req), .err(b_err),
    .err_idx(b_err_idx), .err_clr(b_err_clr), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // SR bank model: S sets, R clears at the clock edge; stuck0 forces Q low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= '0;
    else        bank_q <= (bank_q | flag_S) & ~flag_R;
  end
  assign flag_Q = bank_q & ~stuck0;

  // Track S/R legality and any activity on the 6-flag instance.
  always @(negedge clk) begin
    if (((flag_S & flag_R) != '0) || !$onehot0(flag_S | flag_R)) inv_viol++;
    if ((b_flag_S | b_flag_R) != '0) b_act++;
    if (b_done) b_done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int model_grant(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0; err_clr = 1'b0; b_valid = '0; b_err_clr = 1'b0; stuck0 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    sb_req.delete();
    sb_due.delete();
  endtask

  task automatic test_reset();
    req_valid = 4'hF; req_op = '0; req_idx = '0; err_clr = 1'b0;
    b_valid = '0; b_op = '0; b_idx = '0; b_err_clr = 1'b0; stuck0 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (flag_S !== 8'h00) begin failures++; $display("FAIL reset_flag_S: got %h want 00", flag_S); end
    checks++; if (flag_R !== 8'h00) begin failures++; $display("FAIL reset_flag_R: got %h want 00", flag_R); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (done_req !== 2'd0) begin failures++; $display("FAIL reset_done_req: got %0d want 0", done_req); end
    checks++; if (err !== 1'b0 || err_idx !== 3'd0) begin failures++; $display("FAIL reset_err: got err=%b idx=%0d want 0/0", err, err_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0010; req_op = 4'b0010; req_idx[1*IDXW +: IDXW] = 3'd5;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    sb_req.push_back(1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (flag_S !== 8'h20 || flag_R !== 8'h00) begin failures++; $display("FAIL single_drive: S=%h R=%h want S=20 R=00", flag_S, flag_R); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk); #1;
    checks++; if (flag_S !== 8'h00 || done !== 1'b0) begin failures++; $display("FAIL single_check: S=%h done=%b want 00/0", flag_S, done); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", done); end
    if (done === 1'b1 && sb_req.size() > 0) begin
      checks++; if (done_req !== 2'(sb_req[0])) begin failures++; $display("FAIL single_done_req: got %0d want %0d", done_req, sb_req[0]); end
      void'(sb_req.pop_front());
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_after: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] last, exp_ready;
    logic [NFLAG-1:0] pend_s, pend_r;
    logic [IDXW-1:0] gi;
    logic exp_done;
    int busy_left, g;
    apply_reset();
    last = '0; busy_left = 0; pend_s = '0; pend_r = '0;
    req_op = 4'hF;
    for (int i = 0; i < NREQ; i++) req_idx[i*IDXW +: IDXW] = IDXW'(i);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = req_valid & ~last;
      if (k == 0)  req_valid = 4'hF;
      if (k == 13) req_valid = 4'b1001;
      #1;
      checks++; if (flag_S !== pend_s || flag_R !== pend_r) begin failures++; $display("FAIL rr_drive k=%0d: S=%h R=%h want S=%h R=%h", k, flag_S, flag_R, pend_s, pend_r); end
      pend_s = '0; pend_r = '0; exp_ready = '0;
      if (busy_left == 0 && req_valid != '0) begin
        g = model_grant(req_valid, mptr);
        exp_ready = 4'(1) << g;
        mptr = (g + 1) % NREQ;
        busy_left = 2;
        gi = req_idx[g*IDXW +: IDXW];
        if (req_op[g]) pend_s = 8'(1) << gi; else pend_r = 8'(1) << gi;
        sb_req.push_back(g); sb_due.push_back(k + 3);
      end else if (busy_left > 0) busy_left--;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, exp_ready); end
      exp_done = (sb_due.size() > 0) && (sb_due[0] == k);
      checks++; if (done !== exp_done) begin failures++; $display("FAIL rr_done k=%0d: got %b want %b", k, done, exp_done); end
      if (exp_done) begin
        checks++; if (done_req !== 2'(sb_req[0])) begin failures++; $display("FAIL rr_done_req k=%0d: got %0d want %0d", k, done_req, sb_req[0]); end
        void'(sb_req.pop_front()); void'(sb_due.pop_front());
      end
      last = exp_ready;
    end
    checks++; if (sb_req.size() != 0) begin failures++; $display("FAIL rr_pending: %0d commands never completed, want 0", sb_req.size()); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] last, exp_ready;
    logic [NFLAG-1:0] pend_s, pend_r;
    logic [IDXW-1:0] gi;
    logic exp_done;
    int busy_left, g;
    apply_reset();
    last = '0; busy_left = 0; pend_s = '0; pend_r = '0;
    req_op = 4'b0001;
    req_idx[0*IDXW +: IDXW] = 3'd2;
    req_idx[1*IDXW +: IDXW] = 3'd2;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req_valid = req_valid & ~last;
      if (k == 0) req_valid = 4'b0011;
      #1;
      checks++; if (flag_S !== pend_s || flag_R !== pend_r) begin failures++; $display("FAIL b2b_drive k=%0d: S=%h R=%h want S=%h R=%h", k, flag_S, flag_R, pend_s, pend_r); end
      pend_s = '0; pend_r = '0; exp_ready = '0;
      if (busy_left == 0 && req_valid != '0) begin
        g = model_grant(req_valid, mptr);
        exp_ready = 4'(1) << g;
        mptr = (g + 1) % NREQ;
        busy_left = 2;
        gi = req_idx[g*IDXW +: IDXW];
        if (req_op[g]) pend_s = 8'(1) << gi; else pend_r = 8'(1) << gi;
        sb_req.push_back(g); sb_due.push_back(k + 3);
      end else if (busy_left > 0) busy_left--;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL b2b_grant k=%0d: got %b want %b", k, req_ready, exp_ready); end
      exp_done = (sb_due.size() > 0) && (sb_due[0] == k);
      checks++; if (done !== exp_done) begin failures++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done, exp_done); end
      if (exp_done) begin
        checks++; if (done_req !== 2'(sb_req[0])) begin failures++; $display("FAIL b2b_done_req k=%0d: got %0d want %0d", k, done_req, sb_req[0]); end
        void'(sb_req.pop_front()); void'(sb_due.pop_front());
      end
      last = exp_ready;
    end
    checks++; if (bank_q[2] !== 1'b0) begin failures++; $display("FAIL b2b_final_q2: got %b want 0", bank_q[2]); end
    checks++; if (sb_req.size() != 0) begin failures++; $display("FAIL b2b_pending: %0d commands never completed, want 0", sb_req.size()); end
  endtask

  task automatic test_retry();
    logic [NFLAG-1:0] exp_s;
    int dcnt;
    apply_reset();
    stuck0 = 8'h08;
    dcnt = 0;
    @(negedge clk);
    req_valid = 4'b0001; req_op = 4'b0001; req_idx[0 +: IDXW] = 3'd3;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL retry_grant: got %b want 0001", req_ready); end
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      exp_s = (k == 1 || k == 3 || k == 5) ? 8'h08 : 8'h00;
      checks++; if (flag_S !== exp_s || flag_R !== 8'h00) begin failures++; $display("FAIL retry_drive k=%0d: S=%h R=%h want S=%h R=00", k, flag_S, flag_R, exp_s); end
      checks++; if (err !== (k >= 7)) begin failures++; $display("FAIL retry_err k=%0d: got %b want %b", k, err, (k >= 7)); end
      if (done) dcnt++;
    end
    checks++; if (dcnt != 0) begin failures++; $display("FAIL retry_no_done: got %0d done pulses want 0", dcnt); end
    checks++; if (err_idx !== 3'd3) begin failures++; $display("FAIL retry_err_idx: got %0d want 3", err_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL retry_busy: got %b want 0", busy); end
    stuck0 = '0;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    b_valid = 4'b0001; b_op = 4'b0001; b_idx[0 +: IDXW] = 3'd7;
    #1;
    checks++; if (b_ready !== 4'b0001) begin failures++; $display("FAIL oor_grant: got %b want 0001", b_ready); end
    @(negedge clk);
    b_valid = '0;
    #1;
    checks++; if (b_err !== 1'b1 || b_err_idx !== 3'd7) begin failures++; $display("FAIL oor_err: err=%b idx=%0d want 1/7", b_err, b_err_idx); end
    checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin failures++; $display("FAIL oor_idle: busy=%b done=%b want 0/0", b_busy, b_done); end
    @(negedge clk);
    b_err_clr = 1'b1;
    b_valid = 4'b0010; b_op = 4'b0010; b_idx[1*IDXW +: IDXW] = 3'd6;
    #1;
    checks++; if (b_ready !== 4'b0010) begin failures++; $display("FAIL oor_grant2: got %b want 0010", b_ready); end
    @(negedge clk);
    b_err_clr = 1'b0; b_valid = '0;
    #1;
    checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL oor_clr_vs_err: got %b want 1", b_err); end
    @(negedge clk);
    b_err_clr = 1'b1;
    @(negedge clk);
    b_err_clr = 1'b0;
    #1;
    checks++; if (b_err !== 1'b0 || b_err_idx !== 3'd0) begin failures++; $display("FAIL oor_cleared: err=%b idx=%0d want 0/0", b_err, b_err_idx); end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    apply_reset();
    dcnt = 0;
    @(negedge clk);
    req_valid = 4'b0100; req_op = 4'b0100; req_idx[2*IDXW +: IDXW] = 3'd1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (flag_S !== 8'h02) begin failures++; $display("FAIL rmid_drive: got %h want 02", flag_S); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (flag_S !== 8'h00 || flag_R !== 8'h00) begin failures++; $display("FAIL rmid_sr_clear: S=%h R=%h want 00/00", flag_S, flag_R); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done) dcnt++;
    end
    checks++; if (dcnt != 0) begin failures++; $display("FAIL rmid_no_done: got %0d done pulses want 0", dcnt); end
    @(negedge clk);
    req_valid = 4'b1001; req_op = 4'b1001;
    req_idx[0*IDXW +: IDXW] = 3'd4; req_idx[3*IDXW +: IDXW] = 3'd0;
    #1;
    checks++; if (req_ready !== 4'(1) << model_grant(req_valid, mptr)) begin failures++; $display("FAIL rmid_ptr: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (done !== 1'b1 || done_req !== 2'd0) begin failures++; $display("FAIL rmid_done: done=%b req=%0d want 1/0", done, done_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_retry();
    test_out_of_range();
    test_reset_mid();
    @(negedge clk);
    checks++; if (inv_viol != 0) begin failures++; $display("FAIL sr_invariant: got %0d bad cycles want 0", inv_viol); end
    checks++; if (b_act != 0) begin failures++; $display("FAIL oor_no_drive: got %0d active cycles want 0", b_act); end
    checks++; if (b_done_cnt != 0) begin failures++; $display("FAIL oor_no_done: got %0d done pulses want 0", b_done_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
